// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB3-Lite master port between several requesters.
// Address phases are buffered per master and issued one per bus-ready cycle.
module ahb_master_arbiter #(
   parameter int MASTERS = 2
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic [31:0] s_mhaddr_i  [MASTERS],
   input  logic [1:0]  s_mhtrans_i [MASTERS],
   input  logic        s_mhwrite_i [MASTERS],
   input  logic [2:0]  s_mhsize_i  [MASTERS],
   input  logic [31:0] s_mhwdata_i [MASTERS],
   output logic [31:0] s_mhrdata_o [MASTERS],
   output logic        s_mhready_o [MASTERS],
   output logic        s_mhresp_o  [MASTERS],
   output logic [31:0] s_shaddr_o,
   output logic [1:0]  s_shtrans_o,
   output logic        s_shwrite_o,
   output logic [2:0]  s_shsize_o,
   output logic [31:0] s_shwdata_o,
   input  logic [31:0] s_shrdata_i,
   input  logic        s_shready_i,
   input  logic        s_shresp_i
);

   localparam int SELMSB = (MASTERS < 2) ? 0 : $clog2(MASTERS) - 1;
   localparam int SELW   = SELMSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DATA = 2'd2
   } st_t;

   st_t              r_st     [MASTERS];
   st_t              w_st_nxt [MASTERS];
   logic [31:0]      r_paddr  [MASTERS];
   logic             r_pwrite [MASTERS];
   logic [2:0]       r_psize  [MASTERS];
   logic             w_rdy    [MASTERS];
   logic             w_own    [MASTERS];
   logic             w_cap    [MASTERS];
   logic [SELMSB:0]  r_downer;
   logic [SELMSB:0]  r_last;
   logic             r_dactive;
   logic [SELMSB:0]  w_win;
   logic             w_any;
   logic             w_issue;
   int               w_idx;

   // Search from the master after the last grant; lowest offset wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = 0;
      for (int i = MASTERS; i >= 1; i--) begin
         w_idx = (int'(r_last) + i) % MASTERS;
         if (r_st[w_idx] == ST_PEND) begin
            w_any = 1'b1;
            w_win = w_idx[SELMSB:0];
         end
      end
   end

   assign w_issue = s_shready_i & w_any;

   always_comb begin
      for (int m = 0; m < MASTERS; m++) begin
         w_own[m] = (r_st[m] == ST_DATA) && r_dactive
                    && (int'(r_downer) == m);
         w_rdy[m] = (r_st[m] == ST_IDLE) || (w_own[m] && s_shready_i);
         w_cap[m] = w_rdy[m] && (s_mhtrans_i[m] == 2'd2);
         s_mhready_o[m] = w_rdy[m];
         s_mhresp_o[m]  = w_own[m] ? s_shresp_i : 1'b0;
         s_mhrdata_o[m] = w_own[m] ? s_shrdata_i : 32'd0;
      end
   end

   always_comb begin
      for (int m = 0; m < MASTERS; m++) begin
         w_st_nxt[m] = r_st[m];
         if (w_rdy[m]) begin
            w_st_nxt[m] = w_cap[m] ? ST_PEND : ST_IDLE;
         end
         if (w_issue && (int'(w_win) == m)) begin
            w_st_nxt[m] = ST_DATA;
         end
      end
   end

   always_comb begin
      s_shtrans_o = 2'd0;
      s_shaddr_o  = 32'd0;
      s_shwrite_o = 1'b0;
      s_shsize_o  = 3'd0;
      if (w_issue) begin
         s_shtrans_o = 2'd2;
         s_shaddr_o  = r_paddr[w_win];
         s_shwrite_o = r_pwrite[w_win];
         s_shsize_o  = r_psize[w_win];
      end
   end

   assign s_shwdata_o = s_mhwdata_i[r_downer];

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         for (int m = 0; m < MASTERS; m++) begin
            r_st[m]     <= ST_IDLE;
            r_paddr[m]  <= 32'd0;
            r_pwrite[m] <= 1'b0;
            r_psize[m]  <= 3'd0;
         end
         r_downer  <= '0;
         r_dactive <= 1'b0;
         r_last    <= SELW'(MASTERS - 1);
      end else begin
         for (int m = 0; m < MASTERS; m++) begin
            r_st[m] <= w_st_nxt[m];
            if (w_cap[m]) begin
               r_paddr[m]  <= s_mhaddr_i[m];
               r_pwrite[m] <= s_mhwrite_i[m];
               r_psize[m]  <= s_mhsize_i[m];
            end
         end
         // Ownership only moves on a bus-ready cycle.
         if (s_shready_i) begin
            if (w_any) begin
               r_downer  <= w_win;
               r_dactive <= 1'b1;
               r_last    <= w_win;
            end else begin
               r_dactive <= 1'b0;
            end
         end
      end
   end

endmodule
